// File: rtl/blackjack_pkg.sv
// Shared constants, FSM state type and card encoding for the shoe dealer.
package blackjack_pkg;

    localparam int NUM_CARDS = 52;
    localparam int NUM_RANKS = 13;

    typedef enum logic [1:0] {IDLE, PICK, PROBE, DEAL} state_t;

    // Card index 0..51 -> {suit[1:0], 2'b00, rank[3:0]}, rank 1 = ace.
    function automatic logic [7:0] encode_card(input logic [5:0] idx);
        logic [1:0] suit;
        logic [3:0] rank;
        suit = 2'(idx / 6'd13);
        rank = 4'(idx % 6'd13) + 4'd1;
        return {suit, 2'b00, rank};
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running Galois LFSR; an all-zero seed is forced to 1 so it never locks up.
module lfsr_galois #(
    parameter int                WIDTH = 16,
    parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0]  SEED  = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [WIDTH-1:0] SEED_NZ =
        (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

    // Shift right every cycle, folding the feedback mask in when bit 0 falls out.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_o <= SEED_NZ;
        else if (state_o[0])
            state_o <= (state_o >> 1) ^ TAPS;
        else
            state_o <= state_o >> 1;
    end

endmodule

// File: rtl/blackjack_shoe_dealer.sv
// Deals cards from a NUM_DECKS shoe without exceeding each card's multiplicity.
module blackjack_shoe_dealer
    import blackjack_pkg::*;
#(
    parameter int                    NUM_DECKS  = 1,
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 16'hB400,
    parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1,
    localparam int                   CL_W       = $clog2(52*NUM_DECKS+1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            request_card_i,
    input  logic            shuffle_i,
    output logic            card_valid_o,
    output logic [7:0]      card_to_send_o,
    output logic            busy_o,
    output logic            shoe_empty_o,
    output logic [CL_W-1:0] cards_left_o
);

    localparam int              CW    = $clog2(NUM_DECKS+1);
    localparam logic [CW-1:0]   DECKS = CW'(NUM_DECKS);
    localparam logic [CL_W-1:0] FULL  = CL_W'(NUM_CARDS*NUM_DECKS);

    state_t                  state;
    logic                    req_q;
    logic                    req_edge;
    logic [5:0]              cand;
    logic [5:0]              pick_idx;
    logic [LFSR_WIDTH-1:0]   lfsr;
    logic                    lfsr_unused;
    logic [CW-1:0]           cnt [NUM_CARDS];

    lfsr_galois #(.WIDTH(LFSR_WIDTH), .TAPS(LFSR_TAPS), .SEED(SEED)) u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .state_o (lfsr)
    );

    // Only the low six bits pick the candidate; the rest just feed the sequence.
    assign lfsr_unused  = ^lfsr[LFSR_WIDTH-1:6];
    assign pick_idx     = (lfsr[5:0] < 6'd52) ? lfsr[5:0] : lfsr[5:0] - 6'd52;
    assign req_edge     = request_card_i & ~req_q;
    assign shoe_empty_o = (cards_left_o == '0);

    // Deal FSM: pick a candidate, linear-probe to a free card, then deal it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            req_q          <= 1'b0;
            cand           <= '0;
            card_valid_o   <= 1'b0;
            card_to_send_o <= 8'h00;
            busy_o         <= 1'b0;
            cards_left_o   <= FULL;
            for (int i = 0; i < NUM_CARDS; i++) cnt[i] <= '0;
        end else begin
            req_q        <= request_card_i;
            card_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    // Shuffle has priority; a simultaneous request edge is lost.
                    if (shuffle_i) begin
                        for (int i = 0; i < NUM_CARDS; i++) cnt[i] <= '0;
                        cards_left_o <= FULL;
                    end else if (req_edge && !shoe_empty_o) begin
                        state  <= PICK;
                        busy_o <= 1'b1;
                    end
                end
                PICK: begin
                    cand  <= pick_idx;
                    state <= PROBE;
                end
                PROBE: begin
                    // Shoe is non-empty on entry, so this loop always finds a card.
                    if (cnt[cand] < DECKS)
                        state <= DEAL;
                    else
                        cand <= (cand == 6'd51) ? 6'd0 : cand + 6'd1;
                end
                DEAL: begin
                    cnt[cand]      <= cnt[cand] + CW'(1);
                    cards_left_o   <= cards_left_o - CL_W'(1);
                    card_to_send_o <= encode_card(cand);
                    card_valid_o   <= 1'b1;
                    busy_o         <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blackjack_shoe_dealer.sv
// Directed bench: one- and two-deck shoes checked against a small LFSR/shoe model.
module tb_blackjack_shoe_dealer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req1 = 1'b0, shf1 = 1'b0, req2 = 1'b0, shf2 = 1'b0;
    logic       cv1, cv2, busy1, busy2, emp1, emp2;
    logic [7:0] code1, code2;
    logic [5:0] left1;
    logic [6:0] left2;

    blackjack_shoe_dealer #(.NUM_DECKS(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .request_card_i(req1), .shuffle_i(shf1),
        .card_valid_o(cv1), .card_to_send_o(code1), .busy_o(busy1),
        .shoe_empty_o(emp1), .cards_left_o(left1)
    );

    blackjack_shoe_dealer #(.NUM_DECKS(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .request_card_i(req2), .shuffle_i(shf2),
        .card_valid_o(cv2), .card_to_send_o(code2), .busy_o(busy2),
        .shoe_empty_o(emp2), .cards_left_o(left2)
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference LFSR, reset together with both DUTs.
    function automatic logic [15:0] lstep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    logic [15:0] lfsr_m;
    always @(posedge clk) lfsr_m <= rst ? 16'hACE1 : lstep(lfsr_m);

    int mcnt [2][52];
    int mleft [2];
    int wraps = 0;
    int seen [2][52];

    task automatic model_clear(input int w);
        for (int i = 0; i < 52; i++) mcnt[w][i] = 0;
        mleft[w] = 52 * (w + 1);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        int nv;
        nv = 0;
        rst = 1'b1;
        repeat (2) begin tick(); if (cv1 | cv2) nv++; end
        rst = 1'b0;
        model_clear(0);
        model_clear(1);
        chk("rst_novalid", nv, 0);
    endtask

    task automatic set_req(input int w, input logic v);
        if (w == 0) req1 = v; else req2 = v;
    endtask

    // One request held high; checks latency, code, count and single pulse.
    task automatic deal(input int w, output logic [7:0] got);
        logic [15:0] p;
        logic [7:0]  exp;
        int cand, n, c, extra;
        bit hit;
        set_req(w, 1'b1);
        tick();
        p = lfsr_m;
        chk("busy_pick", (w != 0) ? busy2 : busy1, 1);
        cand = (p[5:0] < 6'd52) ? int'(p[5:0]) : int'(p[5:0]) - 52;
        n = 0;
        while (mcnt[w][cand] >= w + 1 && n < 52) begin
            if (cand == 51) wraps++;
            cand = (cand + 1) % 52;
            n++;
        end
        exp = {2'(cand / 13), 2'b00, 4'(cand % 13 + 1)};
        c = 1;
        hit = 1'b0;
        while (!hit && c < 80) begin
            tick();
            c++;
            hit = (w != 0) ? cv2 : cv1;
        end
        chk("valid_seen", hit, 1);
        chk("latency", c, 4 + n);
        got = (w != 0) ? code2 : code1;
        chk("code", got, exp);
        mcnt[w][cand]++;
        mleft[w]--;
        chk("cards_left", (w != 0) ? 32'(left2) : 32'(left1), mleft[w]);
        chk("busy_done", (w != 0) ? busy2 : busy1, 0);
        if (got[3:0] >= 4'd1 && got[3:0] <= 4'd13 && got[5:4] == 2'b00)
            seen[w][got[7:6] * 13 + got[3:0] - 1]++;
        extra = 0;
        repeat (6) begin tick(); if ((w != 0) ? cv2 : cv1) extra++; end
        chk("one_pulse", extra, 0);
        set_req(w, 1'b0);
        tick();
    endtask

    initial begin
        logic [7:0] first_code, c;
        int nv, nb, nd;

        for (int i = 0; i < 52; i++) begin seen[0][i] = 0; seen[1][i] = 0; end
        do_reset();

        // Reset state
        chk("rst_code", code1, 8'h00);
        chk("rst_left1", left1, 52);
        chk("rst_left2", left2, 104);
        chk("rst_busy", busy1 | busy2, 0);
        chk("rst_empty", emp1 | emp2, 0);
        nv = 0;
        repeat (10) begin tick(); if (cv1 | cv2) nv++; end
        chk("idle_novalid", nv, 0);

        // Single held request, then the rest of the one-deck shoe
        deal(0, first_code);
        for (int i = 1; i < 52; i++) deal(0, c);
        nd = 0;
        for (int i = 0; i < 52; i++) if (seen[0][i] == 1) nd++;
        chk("distinct1", nd, 52);
        chk("empty1", emp1, 1);
        chk("left1_zero", left1, 0);

        // Request on an empty shoe is ignored
        nv = 0; nb = 0;
        req1 = 1'b1;
        repeat (10) begin tick(); if (cv1) nv++; if (busy1) nb++; end
        req1 = 1'b0;
        tick();
        chk("empty_novalid", nv, 0);
        chk("empty_nobusy", nb, 0);

        // Shuffle with a request edge in the same cycle: shuffle wins
        shf1 = 1'b1; req1 = 1'b1;
        tick();
        shf1 = 1'b0;
        chk("shuf_left", left1, 52);
        chk("shuf_empty", emp1, 0);
        nv = 0; nb = 0;
        repeat (8) begin tick(); if (cv1) nv++; if (busy1) nb++; end
        chk("shuf_novalid", nv, 0);
        chk("shuf_nobusy", nb, 0);
        req1 = 1'b0;
        tick();
        model_clear(0);
        deal(0, c);

        // Two-deck shoe: every code exactly twice
        for (int i = 0; i < 104; i++) deal(1, c);
        nd = 0;
        for (int i = 0; i < 52; i++) if (seen[1][i] == 2) nd++;
        chk("twice2", nd, 52);
        chk("empty2", emp2, 1);
        chk("wrap_exercised", (wraps > 0) ? 1 : 0, 1);

        // Reset while in PROBE, then replay the first-run timing
        do_reset();
        repeat (10) tick();
        req1 = 1'b1;
        tick();
        tick();
        chk("probe_busy", busy1, 1);
        req1 = 1'b0;
        do_reset();
        chk("mid_left", left1, 52);
        chk("mid_busy", busy1, 0);
        chk("mid_code", code1, 8'h00);
        repeat (10) tick();
        deal(0, c);
        chk("replay_code", c, first_code);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/blackjack_shoe_dealer.md
# blackjack_shoe_dealer

Parametrised successor to the single-deck random card source: deals cards from a shoe of `NUM_DECKS` standard 52-card decks and never repeats a card beyond its multiplicity. It uses a free-running Galois LFSR for candidate selection, a per-card dealt counter, and a request/valid handshake. It sits between the game controller (requester) and the hand accumulators (consumers of `card_to_send_o`).

## Interface
- `NUM_DECKS`, 1: decks in the shoe, range 1..8.
- `LFSR_WIDTH`, 16: LFSR width, at least 8.
- `LFSR_TAPS`, 16'hB400: Galois feedback mask.
- `SEED`, 16'hACE1: LFSR reset value. A value of 0 is replaced by 1.
- Derived localparam `CL_W` = $clog2(52*NUM_DECKS+1).
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `request_card_i` in 1: deal request. Only its rising edge counts.
- `shuffle_i` in 1: refill the shoe. Level-sampled, acted on only in IDLE.
- `card_valid_o` out 1: one-cycle pulse when a new card is presented.
- `card_to_send_o` out 8: `[7:6]` suit 0..3, `[5:4]` always 0, `[3:0]` rank 1..13 (1 = ace, 11..13 = J/Q/K).
- `busy_o` out 1: high in any state other than IDLE.
- `shoe_empty_o` out 1: high when `cards_left_o` == 0.
- `cards_left_o` out CL_W: cards remaining in the shoe.

## Operation
- Card index: idx 0..51. Rank = idx%13+1. Suit = idx/13.
- Dealt counters: `cnt[idx]`, $clog2(NUM_DECKS+1) bits each. A card is available when `cnt[idx]` < NUM_DECKS.
- LFSR:
  - Advances every cycle, including in IDLE, so request timing adds entropy.
  - Reset loads SEED.
- Request edge: `req_q` registers `request_card_i`; an edge is `request_card_i & ~req_q`. Holding the line high deals exactly one card.
- FSM states:
  - IDLE: on an edge with `shoe_empty_o`=0, go to PICK. An edge while empty is ignored and produces no pulse. An edge while busy is dropped, not queued.
  - PICK: `cand = lfsr[5:0]` if < 52, else `lfsr[5:0]-52`. Go to PROBE.
  - PROBE: if `cand` is available, go to DEAL. Otherwise `cand` = (`cand`+1) mod 52 (wraps 51→0) and stay in PROBE.
  - DEAL: `cnt[cand]`++, `cards_left_o`--, register `card_to_send_o`, pulse `card_valid_o`. Go to IDLE.
- Because `cards_left_o` > 0 on entry, PROBE always terminates within 52 checks.
- Shuffle: in IDLE with `shuffle_i`=1, clear all `cnt` and set `cards_left_o` = 52*NUM_DECKS in one cycle. If a request edge arrives in the same cycle, shuffle wins and the edge is dropped. `shuffle_i` is ignored while busy.
- `card_to_send_o` holds the last dealt card until the next DEAL.
- Reset mid-operation: abandons any deal with no `card_valid_o` pulse. All state returns to reset values.

## Timing
- Reset values:
  - `card_valid_o`=0, `card_to_send_o`=8'h00, `busy_o`=0.
  - `cards_left_o`=52*NUM_DECKS, `shoe_empty_o`=0.
  - All `cnt`=0, `req_q`=0, LFSR=SEED, state IDLE.
- Edge sampled at clock k:
  - PICK in cycle k+1, PROBE in k+2.
  - If the first candidate is free: DEAL in k+3, and `card_valid_o` with the new card appears after edge k+3.
  - Each occupied probe adds 1 cycle. Worst case is 51 extra cycles.
- `cards_left_o` and `shoe_empty_o` update in the same cycle as `card_valid_o`.
- `busy_o` is high from cycle k+1 through the DEAL cycle.

## Structure
- Package `blackjack_pkg`:
  - Constants NUM_CARDS=52 and NUM_RANKS=13.
  - State enum {IDLE, PICK, PROBE, DEAL}.
  - Function `encode_card(idx)` returning the 8-bit card code.
- Sub-module `lfsr_galois`: parameters WIDTH, TAPS, SEED; ports `clk_i`, `rst_i`, `state_o`.
- Top module holds the FSM, counters, edge detector and output registers.

## Test plan
- Reset: after `rst_i` pulse → `card_to_send_o`=8'h00, `cards_left_o`=52, `busy_o`=0, no `card_valid_o` for 10 idle cycles.
- Single request, held high 10 cycles → exactly one `card_valid_o` pulse, at least 4 cycles after the edge. Code has `[5:4]`=0, rank 1..13, and `cards_left_o`=51.
- NUM_DECKS=1, 52 separated requests → 52 distinct codes, then `shoe_empty_o`=1. A 53rd request gives no pulse and `busy_o` stays 0.
- NUM_DECKS=2, 104 requests → each of the 52 codes seen exactly twice. Probe wrap (51→0) observed.
- Shuffle after empty, with a request edge in the same cycle → `cards_left_o`=52 and no deal. The next request deals normally.
- `rst_i` asserted during PROBE → no pulse, `cards_left_o` returns to 52, and the next deal after reset matches a fresh-reset run with identical request timing.
